or_accumulate_32: RTL and testbench

- Sequential front-end that consumes a stream of 32-bit words and reduces them with bitwise OR into one 32-bit result.
- Instantiates the existing bitwise_or_32 combinational stage as its datapath: running accumulator on port a, incoming word on port b, next accumulator taken from port c.
- Sits between a word producer (valid/ready stream) and a result consumer (valid/ready).
- Used for mask merging and flag aggregation across N words.

---
 rtl/or_accumulate_32_pkg.sv | 14 +
 rtl/bitwise_or_32.sv | 10 +
 rtl/or_accumulate_32.sv | 101 ++++++++++
 tb/tb_or_accumulate_32.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/or_accumulate_32_pkg.sv
// Shared constants and state encoding for the OR-reduction front-end.
// Encoding 2'd3 is unused and recovers to IDLE.
package or_accumulate_32_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int COUNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bitwise_or_32.sv
// Combinational 32-bit bitwise OR stage; c = a | b.
module bitwise_or_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c
);

    assign c = a | b;

endmodule

// File: rtl/or_accumulate_32.sv
// Valid/ready front-end that OR-reduces len words into one result.
//   state | meaning
//   IDLE  | waiting for start; out_data holds the last result
//   ACCUM | accepting words, one per cycle, until remaining hits terminal count
//   DONE  | result presented on out_valid until out_ready
module or_accumulate_32
    import or_accumulate_32_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy,
    output logic [COUNT_W-1:0] count
);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   or_c;
    logic [COUNT_W-1:0] remaining;
    logic [COUNT_W-1:0] remaining_nxt;
    logic [COUNT_W-1:0] count_nxt;

    bitwise_or_32 u_or (
        .a (acc),
        .b (in_data),
        .c (or_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            remaining <= '0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            remaining <= remaining_nxt;
            count     <= count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        remaining_nxt = remaining;
        count_nxt     = count;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    acc_nxt   = '0;
                    count_nxt = '0;
                    if (len != '0) begin
                        remaining_nxt = len;
                        state_nxt     = ST_ACCUM;
                    end else begin
                        remaining_nxt = '0;
                        state_nxt     = ST_DONE;
                    end
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_nxt       = or_c;
                    remaining_nxt = remaining - COUNT_W'(1);
                    count_nxt     = count + COUNT_W'(1);
                    if (remaining == COUNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // acc is only rewritten on start or beats, so it doubles as the held result.
    assign out_data = acc;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_or_accumulate_32.sv
// Bench for or_accumulate_32: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_or_accumulate_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic [7:0]  count;

    int n_vec = 0;
    int n_err = 0;

    or_accumulate_32 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 waiting, 1 collecting words, 2 result pending.
    int          m_phase = 0;
    int          m_need  = 0;
    int          m_count = 0;
    logic [31:0] m_result = '0;
    logic [31:0] m_words[$];
    bit          m_live = 0;

    function automatic logic [31:0] or_reduce(input logic [31:0] w[$]);
        logic [31:0] r = '0;
        foreach (w[i]) r = r | w[i];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase  = 0;
            m_count  = 0;
            m_result = '0;
            m_words.delete();
            m_live   = 1;
        end else if (m_phase == 0) begin
            if (start) begin
                m_words.delete();
                m_count = 0;
                if (len == 0) begin
                    m_result = '0;
                    m_phase  = 2;
                end else begin
                    m_need  = int'(len);
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (in_valid) begin
                m_words.push_back(in_data);
                m_count++;
                m_need--;
                if (m_need == 0) begin
                    m_result = or_reduce(m_words);
                    m_phase  = 2;
                end
            end
        end else if (out_ready) begin
            m_phase = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_live) begin
            chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("count", 32'(count), 32'(m_count));
            if (m_phase != 1) chk("out_data", out_data, m_result);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input int gap);
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] acc_exp;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // reset with random inputs
        repeat (2) begin
            start = 1'($urandom); len = 8'($urandom); in_valid = 1'($urandom);
            in_data = $urandom; out_ready = 1'($urandom);
            tick();
        end
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // basic back-to-back
        do_start(8'd2);
        beat(32'hFFFF0000, 0);
        beat(32'h0000FF00, 0);
        chk("basic_out_valid", 32'(out_valid), 32'd1);
        chk("basic_out_data", out_data, 32'hFFFFFF00);
        chk("basic_count", 32'(count), 32'd2);
        tick();
        chk("basic_idle", 32'(busy), 32'd0);

        // gapped input
        do_start(8'd3);
        beat(32'hFFFF0000, 0);
        beat(32'h000F00FF, 2);
        beat(32'h000F0000, 2);
        chk("gap_out_data", out_data, 32'hFFFF00FF);
        chk("gap_count", 32'(count), 32'd3);
        tick();

        // backpressure with a start pulse during the stall
        out_ready = 1'b0;
        do_start(8'd1);
        beat(32'hFFFF0000, 0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd3;
            chk("bp_out_data", out_data, 32'hFFFF0000);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_released", 32'(busy), 32'd0);
        tick();
        chk("bp_start_ignored", 32'(busy), 32'd0);
        out_ready = 1'b1;

        // empty transaction, start held through the handshake
        start = 1'b1; len = 8'd0;
        tick();
        chk("empty_out_valid", 32'(out_valid), 32'd1);
        chk("empty_out_data", out_data, 32'h0);
        chk("empty_count", 32'(count), 32'd0);
        tick();
        start = 1'b0;
        chk("empty_start_ignored", 32'(busy), 32'd0);

        // reset mid-ACCUM
        do_start(8'd4);
        beat(32'hFFFF0000, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_start(8'd1);
        beat(32'h000F0000, 0);
        chk("rstmid_out_data", out_data, 32'h000F0000);
        tick();

        // maximum length
        acc_exp = '0;
        do_start(8'd255);
        for (int i = 0; i < 255; i++) begin
            logic [31:0] d;
            d = $urandom & $urandom & $urandom;
            acc_exp |= d;
            beat(d, 0);
        end
        chk("max_count", 32'(count), 32'd255);
        chk("max_out_data", out_data, acc_exp);
        tick();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            start     = ($urandom_range(0, 3) == 0);
            len       = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            in_valid  = 1'($urandom);
            in_data   = $urandom & $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        wait_idle(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
